fft_out_serializer: RTL and testbench
=====================================

FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

Interface
REQ-001 Parameter N, default 16: word width of each real and imaginary sample (signed Q-format).
REQ-002 Parameter Q, default 8: fractional bits; carried through unchanged, no arithmetic uses it.
REQ-003 Parameter BITREV, default 0: 0 streams frame bins in natural index order, 1 streams them in 5-bit bit-reversed order.
REQ-004 clk2  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  capture strobe; asserted for one cycle when the FFT outputs on the input buses are valid.
REQ-007 in_r_bus  input  32*N  flattened real parts; bin k occupies bits [k*N+N-1 : k*N].
REQ-008 in_i_bus  input  32*N  flattened imaginary parts; same packing as in_r_bus.
REQ-009 dout_ready  input  1  downstream accepts the current word.
REQ-010 dout_valid  output  1  dout_r, dout_i, dout_idx and dout_last hold a valid word.
REQ-011 dout_r  output  N  real part of the current bin.
REQ-012 dout_i  output  N  imaginary part of the current bin.
REQ-013 dout_idx  output  5  bin index of the current word (natural index, even when BITREV=1).
REQ-014 dout_last  output  1  high with the final word of a frame.
REQ-015 busy  output  1  high while a captured frame is not fully transferred.
REQ-016 dropped  output  1  one-cycle pulse when a start is rejected.
REQ-017 frame_cnt  output  8  count of fully transferred frames; wraps 255 -> 0.

Function
REQ-018 States SHALL be IDLE and STREAM; busy = (state == STREAM).
REQ-019 IDLE with start=1 at edge k: the module SHALL register both buses into a 64-word frame buffer, set the sequence counter to 0, and enter STREAM.
REQ-020 dout_valid SHALL be 1 from the cycle after edge k, with the first word presented: one-cycle latency from start to the first word.
REQ-021 Word presented at sequence position s SHALL be bin s when BITREV=0, or bin bitrev5(s) when BITREV=1; dout_idx SHALL equal that bin number.
REQ-022 A transfer SHALL occur only on an edge where dout_valid=1 and dout_ready=1; the sequence counter then advances by 1.
REQ-023 While dout_valid=1 and dout_ready=0, all dout_* outputs SHALL hold stable.
REQ-024 dout_last SHALL be 1 only when the sequence position is 31.
REQ-025 On the transfer of position 31: frame_cnt SHALL increment (mod 256); without a simultaneous start the module SHALL return to IDLE with dout_valid=0 on the next cycle.
REQ-026 If start=1 on the same edge as the position-31 transfer, the module SHALL capture the new frame, stay in STREAM, and present position 0 of the new frame on the next cycle with no bubble.
REQ-027 A start at any other time in STREAM SHALL be ignored and SHALL pulse dropped for one cycle; the buffer and the sequence counter SHALL remain unchanged.
REQ-028 dout_valid SHALL never depend combinationally on dout_ready.
REQ-029 Input buses SHALL be sampled only on accepted starts; changes at other times have no effect.

Reset
REQ-030 While rst=1, asynchronously: state=IDLE, sequence counter=0, dout_valid=0, dout_last=0, busy=0, dropped=0, frame_cnt=0, dout_r=0, dout_i=0, dout_idx=0.
REQ-031 Reset asserted mid-frame SHALL discard the frame; after release, the module waits in IDLE for a new start.
REQ-032 Frame buffer contents need no reset.

Verification
REQ-033 Bin k real=k, imag=-k, BITREV=0, ready held 1, single start -> valid the next cycle; 32 consecutive words with idx 0..31, dout_r=k, dout_i=-k; last only on idx 31; frame_cnt=1; busy low after the final word.
REQ-034 Same frame with BITREV=1 -> idx sequence 0,16,8,24,4,...,31; dout_r equals idx for every word.
REQ-035 Ready toggled 1,0,0,1 repeatedly -> outputs stable during every stall; exactly 32 transfers with no loss or duplication.
REQ-036 Start at position 10, then start plus a second frame (real=100+k) on the position-31 transfer -> one dropped pulse at position 10, first frame intact, second frame starts the next cycle with dout_r=100, frame_cnt=2.
REQ-037 rst asserted at position 15 with ready stalled -> all outputs 0 immediately; the next start streams a fresh frame from idx 0.
REQ-038 256 back-to-back frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/fft_out_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fft_out_serializer
// Purpose  : Captures a 32-bin complex FFT frame presented on two flattened
//            buses and streams it out one bin per transfer over a
//            valid/ready handshake, in natural or 5-bit bit-reversed order.
// Revision : 1.0  initial release
// ============================================================================
module fft_out_serializer #(
  parameter int N      = 16,  // sample word width (signed Q-format)
  parameter int Q      = 8,   // fractional bits, metadata only
  parameter int BITREV = 0    // 0: natural order, 1: bit-reversed order
) (
  input  logic            clk2,
  input  logic            rst,
  input  logic            start,
  input  logic [32*N-1:0] in_r_bus,
  input  logic [32*N-1:0] in_i_bus,
  input  logic            dout_ready,
  output logic            dout_valid,
  output logic [N-1:0]    dout_r,
  output logic [N-1:0]    dout_i,
  output logic [4:0]      dout_idx,
  output logic            dout_last,
  output logic            busy,
  output logic            dropped,
  output logic [7:0]      frame_cnt
);

  // A fraction wider than the word is a configuration error.
  if (Q > N) begin : g_q_too_wide
    $error("fft_out_serializer: Q must not exceed N");
  end

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [4:0]     seq_q, seq_d;
  logic [7:0]     fcnt_q, fcnt_d;
  logic           drop_q, drop_d;
  logic [N-1:0]   rbuf_q [32];
  logic [N-1:0]   ibuf_q [32];

  logic           xfer;
  logic           last_xfer;
  logic           capture;
  logic [4:0]     bin;

  function automatic logic [4:0] bitrev5(input logic [4:0] s);
    return {s[0], s[1], s[2], s[3], s[4]};
  endfunction

  // Next-state logic: a start is accepted in IDLE or on the final transfer of
  // a frame, which lets frames run back to back without a bubble.
  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    fcnt_d    = fcnt_q;
    drop_d    = 1'b0;
    xfer      = (state_q == STREAM) && dout_ready;
    last_xfer = xfer && (seq_q == 5'd31);
    capture   = start && ((state_q == IDLE) || last_xfer);

    if (start && (state_q == STREAM) && !last_xfer) begin
      drop_d = 1'b1;
    end

    if (last_xfer) begin
      fcnt_d = fcnt_q + 8'd1;
    end

    if (capture) begin
      seq_d = 5'd0;
    end else if (xfer) begin
      seq_d = seq_q + 5'd1;
    end

    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (last_xfer && !start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers, cleared asynchronously so a mid-frame reset discards it.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      seq_q   <= 5'd0;
      fcnt_q  <= 8'd0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      fcnt_q  <= fcnt_d;
      drop_q  <= drop_d;
    end
  end

  // Frame buffer: loaded only on an accepted start; contents need no reset.
  always_ff @(posedge clk2) begin
    if (capture) begin
      for (int k = 0; k < 32; k++) begin
        rbuf_q[k] <= in_r_bus[k*N +: N];
        ibuf_q[k] <= in_i_bus[k*N +: N];
      end
    end
  end

  // Output mapping: outputs follow registered state only, so valid never
  // depends on ready and everything holds while stalled.
  always_comb begin
    bin        = (BITREV != 0) ? bitrev5(seq_q) : seq_q;
    dout_valid = (state_q == STREAM);
    dout_r     = '0;
    dout_i     = '0;
    dout_idx   = 5'd0;
    dout_last  = 1'b0;
    if (state_q == STREAM) begin
      dout_r    = rbuf_q[bin];
      dout_i    = ibuf_q[bin];
      dout_idx  = bin;
      dout_last = (seq_q == 5'd31);
    end
    busy      = (state_q == STREAM);
    dropped   = drop_q;
    frame_cnt = fcnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_out_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_out_serializer
// Purpose  : Scoreboard bench for fft_out_serializer; one natural-order and
//            one bit-reversed instance share all stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_out_serializer;

  localparam int N = 16;

  typedef struct packed {
    logic [4:0]   idx;
    logic [N-1:0] r;
    logic [N-1:0] i;
    logic         last;
  } exp_t;

  logic            clk2 = 1'b0;
  logic            rst  = 1'b1;
  logic            start = 1'b0;
  logic [32*N-1:0] in_r_bus = '0;
  logic [32*N-1:0] in_i_bus = '0;
  logic            dout_ready = 1'b0;

  logic            v0, l0, b0, d0, v1, l1, b1, d1;
  logic [N-1:0]    r0, i0, r1, i1;
  logic [4:0]      x0, x1;
  logic [7:0]      fc0, fc1;

  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_fc = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [N-1:0] fr [32];
  logic [N-1:0] fi [32];

  fft_out_serializer #(.N(N), .Q(8), .BITREV(0)) u_nat (
    .clk2(clk2), .rst(rst), .start(start), .in_r_bus(in_r_bus),
    .in_i_bus(in_i_bus), .dout_ready(dout_ready), .dout_valid(v0),
    .dout_r(r0), .dout_i(i0), .dout_idx(x0), .dout_last(l0), .busy(b0),
    .dropped(d0), .frame_cnt(fc0)
  );

  fft_out_serializer #(.N(N), .Q(8), .BITREV(1)) u_rev (
    .clk2(clk2), .rst(rst), .start(start), .in_r_bus(in_r_bus),
    .in_i_bus(in_i_bus), .dout_ready(dout_ready), .dout_valid(v1),
    .dout_r(r1), .dout_i(i1), .dout_idx(x1), .dout_last(l1), .busy(b1),
    .dropped(d1), .frame_cnt(fc1)
  );

  always #5 clk2 = ~clk2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] br5(input logic [4:0] s);
    logic [4:0] o;
    for (int b = 0; b < 5; b++) o[4-b] = s[b];
    return o;
  endfunction

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  // Drive fr/fi onto the buses and queue the expected stream of both instances.
  task automatic apply_frame();
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      in_r_bus[k*N +: N] = fr[k];
      in_i_bus[k*N +: N] = fi[k];
    end
    for (int s = 0; s < 32; s++) begin
      e.idx = 5'(s); e.r = fr[s]; e.i = fi[s]; e.last = (s == 31);
      q0.push_back(e);
      e.idx = br5(5'(s)); e.r = fr[br5(5'(s))]; e.i = fi[br5(5'(s))];
      q1.push_back(e);
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    apply_frame();
    tick();
    start = 1'b0;
  endtask

  // Run until both scoreboards are empty; optional 1,0,0,1 ready pattern.
  task automatic drain(input bit stall, input int budget);
    int cyc = 0;
    while ((q0.size() != 0 || q1.size() != 0) && cyc < budget) begin
      if (stall) dout_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else       dout_ready = 1'b1;
      tick();
      cyc++;
    end
    if (cyc >= budget) check("drain_timeout", 32'(q0.size()), 32'd0);
    dout_ready = 1'b1;
  endtask

  // Monitor: pops on every transfer and checks stability across stalls.
  logic         hold0 = 1'b0;
  logic [N-1:0] h_r, h_i;
  logic [4:0]   h_x, h_x1;
  logic         h_l;
  always @(negedge clk2) begin
    exp_t e;
    if (rst) begin
      hold0 = 1'b0;
    end else begin
      if (hold0) begin
        check("hold_valid", 32'(v0), 32'd1);
        check("hold_r", 32'(r0), 32'(h_r));
        check("hold_i", 32'(i0), 32'(h_i));
        check("hold_idx", 32'(x0), 32'(h_x));
        check("hold_last", 32'(l0), 32'(h_l));
        check("hold_idx_rev", 32'(x1), 32'(h_x1));
      end
      if (v0 && dout_ready) begin
        check("nat_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          check("nat_idx", 32'(x0), 32'(e.idx));
          check("nat_r", 32'(r0), 32'(e.r));
          check("nat_i", 32'(i0), 32'(e.i));
          check("nat_last", 32'(l0), 32'(e.last));
        end
      end
      if (v1 && dout_ready) begin
        check("rev_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check("rev_idx", 32'(x1), 32'(e.idx));
          check("rev_r", 32'(r1), 32'(e.r));
          check("rev_i", 32'(i1), 32'(e.i));
          check("rev_last", 32'(l1), 32'(e.last));
        end
      end
      hold0 = v0 && !dout_ready;
      h_r = r0; h_i = i0; h_x = x0; h_l = l0; h_x1 = x1;
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(v0), 32'd0);
    check({tag, "_last"}, 32'(l0), 32'd0);
    check({tag, "_busy"}, 32'(b0), 32'd0);
    check({tag, "_dropped"}, 32'(d0), 32'd0);
    check({tag, "_r"}, 32'(r0), 32'd0);
    check({tag, "_i"}, 32'(i0), 32'd0);
    check({tag, "_idx"}, 32'(x0), 32'd0);
    check({tag, "_idx_rev"}, 32'(x1), 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_idle("rst");
    check("rst_fcnt", 32'(fc0), 32'd0);
    rst = 1'b0;
    dout_ready = 1'b1;
    tick();

    // Basic frame: real=k, imag=-k; also the bit-reversed instance
    for (int k = 0; k < 32; k++) begin fr[k] = N'(k); fi[k] = N'(-k); end
    start_frame();
    check("lat_valid", 32'(v0), 32'd1);
    check("lat_idx", 32'(x0), 32'd0);
    check("lat_idx_rev", 32'(x1), 32'd0);
    tick();
    check("rev_second_idx", 32'(x1), 32'd16);
    drain(1'b0, 200);
    tick();
    exp_fc = 1;
    check("f1_busy", 32'(b0), 32'd0);
    check("f1_valid", 32'(v0), 32'd0);
    check("f1_fcnt", 32'(fc0), 32'(exp_fc));

    // Ready stalls with pattern 1,0,0,1
    for (int k = 0; k < 32; k++) begin fr[k] = N'($urandom); fi[k] = N'($urandom); end
    start_frame();
    drain(1'b1, 400);
    tick();
    exp_fc = 2;
    check("stall_busy", 32'(b0), 32'd0);
    check("stall_fcnt", 32'(fc0), 32'(exp_fc));

    // Rejected start at position 10 with garbage buses, then chained frame
    for (int k = 0; k < 32; k++) begin fr[k] = N'(k); fi[k] = N'(3 * k); end
    start_frame();
    repeat (10) tick();
    start = 1'b1;
    in_r_bus = {32{16'h7777}};
    in_i_bus = {32{16'h5555}};
    tick();
    start = 1'b0;
    check("drop_pulse", 32'(d0), 32'd1);
    check("drop_pulse_rev", 32'(d1), 32'd1);
    check("drop_seq", 32'(x0), 32'd11);
    tick();
    check("drop_clear", 32'(d0), 32'd0);
    repeat (19) tick();
    check("pos31_last", 32'(l0), 32'd1);
    for (int k = 0; k < 32; k++) begin fr[k] = N'(100 + k); fi[k] = N'(-k); end
    start_frame();
    check("chain_valid", 32'(v0), 32'd1);
    check("chain_r", 32'(r0), 32'd100);
    check("chain_idx", 32'(x0), 32'd0);
    check("chain_dropped", 32'(d0), 32'd0);
    drain(1'b0, 200);
    tick();
    exp_fc = 4;
    check("chain_fcnt", 32'(fc0), 32'(exp_fc));

    // Reset mid-frame at position 15 while stalled
    for (int k = 0; k < 32; k++) begin fr[k] = N'(50 + k); fi[k] = N'(k); end
    start_frame();
    repeat (15) tick();
    dout_ready = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_idle("arst");
    check("arst_fcnt", 32'(fc0), 32'd0);
    q0.delete();
    q1.delete();
    tick();
    rst = 1'b0;
    dout_ready = 1'b1;
    tick();
    tick();
    check_idle("post_rst");
    for (int k = 0; k < 32; k++) begin fr[k] = N'(200 + k); fi[k] = N'(7 * k); end
    start_frame();
    check("fresh_idx", 32'(x0), 32'd0);
    check("fresh_r", 32'(r0), 32'd200);
    drain(1'b0, 200);
    tick();
    check("fresh_fcnt", 32'(fc0), 32'd1);

    // 256 back-to-back frames from a cleared counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 32; k++) begin fr[k] = N'($urandom); fi[k] = N'($urandom); end
      start_frame();
      if (f != 0) check("b2b_no_bubble", 32'(x0), 32'd0);
      repeat (31) tick();
    end
    drain(1'b0, 200);
    tick();
    check("wrap_fcnt", 32'(fc0), 32'd0);
    check("wrap_fcnt_rev", 32'(fc1), 32'd0);
    check("wrap_busy", 32'(b0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
